// File: rtl/ahb_lite_mst_if.sv
// AHB-Lite initiator: turns valid/ack commands into pipelined single NONSEQ transfers
// and returns one in-order response per command, including misaligned and ERROR cases.
module ahb_lite_mst_if #(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 pll_core_cpuclk,
    input  logic                 pad_cpu_rst,
    input  logic                 cmd_req,
    input  logic [31:0]          cmd_addr,
    input  logic                 cmd_write,
    input  logic [2:0]           cmd_size,
    input  logic [31:0]          cmd_wdata,
    output logic                 cmd_ack,
    output logic                 rsp_vld,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic [1:0]           mst_yy_htrans,
    output logic [31:0]          mst_yy_haddr,
    output logic [2:0]           mst_yy_hsize,
    output logic                 mst_yy_hwrite,
    output logic [31:0]          mst_yy_hwdata,
    input  logic                 slv_mst_hready,
    input  logic [31:0]          slv_mst_hrdata,
    input  logic [1:0]           slv_mst_hresp,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_e;

    logic                 dp_vld_q, dp_vld_d;
    logic                 dp_write_q, dp_write_d;
    logic [31:0]          dp_wdata_q, dp_wdata_d;
    logic                 err_pend_q, err_pend_d;
    logic                 rsp_vld_q, rsp_vld_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [31:0]          rsp_rdata_q, rsp_rdata_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic    misaligned, can_issue, acc_bus, acc_mis, dp_done, bus_err;
    logic    unused_hresp1;
    htrans_e htrans;

    always_comb begin
        case (cmd_size)
            3'b000:  misaligned = 1'b0;
            3'b001:  misaligned = cmd_addr[0];
            3'b010:  misaligned = |cmd_addr[1:0];
            default: misaligned = 1'b1;
        endcase
        bus_err       = slv_mst_hresp[0];
        unused_hresp1 = slv_mst_hresp[1];

        // Decodes are combinational, so reset gating keeps the bus idle during reset.
        can_issue = cmd_req & ~err_pend_q & ~misaligned & ~pad_cpu_rst;
        acc_bus   = can_issue & slv_mst_hready;
        acc_mis   = cmd_req & misaligned & ~dp_vld_q & ~err_pend_q & ~pad_cpu_rst;
        dp_done   = dp_vld_q & slv_mst_hready;
        htrans    = can_issue ? HTRANS_NONSEQ : HTRANS_IDLE;

        dp_vld_d    = dp_vld_q;
        dp_write_d  = dp_write_q;
        dp_wdata_d  = dp_wdata_q;
        err_pend_d  = err_pend_q;
        rsp_vld_d   = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        err_cnt_d   = err_cnt_q;

        if (acc_bus) begin
            dp_vld_d   = 1'b1;
            dp_write_d = cmd_write;
            dp_wdata_d = cmd_wdata;
        end else if (dp_done) begin
            dp_vld_d = 1'b0;
        end

        if (dp_done) begin
            err_pend_d = 1'b0;
        end else if (dp_vld_q & bus_err & ~slv_mst_hready) begin
            err_pend_d = 1'b1;
        end

        // Misaligned accept requires no outstanding data phase, so both never coincide.
        if (dp_done) begin
            rsp_vld_d   = 1'b1;
            rsp_err_d   = bus_err;
            rsp_rdata_d = (~dp_write_q & ~bus_err) ? slv_mst_hrdata : '0;
            if (bus_err & ~&err_cnt_q) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end else if (acc_mis) begin
            rsp_vld_d = 1'b1;
            rsp_err_d = 1'b1;
        end

        cmd_ack       = acc_bus | acc_mis;
        mst_yy_htrans = htrans;
        mst_yy_haddr  = can_issue ? cmd_addr : '0;
        mst_yy_hsize  = can_issue ? cmd_size : '0;
        mst_yy_hwrite = can_issue & cmd_write;
        mst_yy_hwdata = dp_wdata_q;
        rsp_vld       = rsp_vld_q;
        rsp_err       = rsp_err_q;
        rsp_rdata     = rsp_rdata_q;
        err_cnt       = err_cnt_q;
    end

    always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
        if (pad_cpu_rst) begin
            dp_vld_q    <= 1'b0;
            dp_write_q  <= 1'b0;
            dp_wdata_q  <= '0;
            err_pend_q  <= 1'b0;
            rsp_vld_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            dp_vld_q    <= dp_vld_d;
            dp_write_q  <= dp_write_d;
            dp_wdata_q  <= dp_wdata_d;
            err_pend_q  <= err_pend_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_ahb_lite_mst_if.sv
// Bench for ahb_lite_mst_if: a command-level reference model predicts responses while a
// behavioural slave with wait states and ERROR injection drives the bus side.
module tb_ahb_lite_mst_if;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_req = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic        cmd_write = 1'b0;
    logic [2:0]  cmd_size = '0;
    logic [31:0] cmd_wdata = '0;
    logic        cmd_ack, rsp_vld, rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready = 1'b1;
    logic [31:0] hrdata = '0;
    logic [1:0]  hresp = '0;
    logic [7:0]  err_cnt;

    int checks = 0;
    int failures = 0;
    int exp_errcnt = 0;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          waits;
        bit          err;
        int          gap;
    } cmd_t;

    cmd_t        cmds[$];
    int          ack_cyc[$];
    int          rsp_cyc[$];
    logic [31:0] smem[16];
    logic [31:0] rmem[16];

    always #5 clk = ~clk;

    ahb_lite_mst_if #(.ERR_CNT_W(8)) dut (
        .pll_core_cpuclk(clk),
        .pad_cpu_rst    (rst),
        .cmd_req        (cmd_req),
        .cmd_addr       (cmd_addr),
        .cmd_write      (cmd_write),
        .cmd_size       (cmd_size),
        .cmd_wdata      (cmd_wdata),
        .cmd_ack        (cmd_ack),
        .rsp_vld        (rsp_vld),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .mst_yy_htrans  (htrans),
        .mst_yy_haddr   (haddr),
        .mst_yy_hsize   (hsize),
        .mst_yy_hwrite  (hwrite),
        .mst_yy_hwdata  (hwdata),
        .slv_mst_hready (hready),
        .slv_mst_hrdata (hrdata),
        .slv_mst_hresp  (hresp),
        .err_cnt        (err_cnt)
    );

    function automatic bit is_mis(input cmd_t c);
        return (c.size >= 3'd3) || (c.size == 3'd1 && c.addr[0]) ||
               (c.size == 3'd2 && c.addr[1:0] != 2'b00);
    endfunction

    function automatic cmd_t mk(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                                input logic [31:0] wdata, input int waits, input bit err,
                                input int gap);
        cmd_t c;
        c.addr = addr; c.wr = wr; c.size = size; c.wdata = wdata;
        c.waits = waits; c.err = err; c.gap = gap;
        return c;
    endfunction

    // Runs the queued commands; requester, slave and response scoreboard advance once per cycle.
    task automatic run_cmds(input string name, input int budget);
        int          n, ci, ri, gap_left, t, sl_idx, sl_waits, sl_eph;
        bit          sl_busy, pend2, req_now, mis_now, exp_ack;
        logic [1:0]  exp_trans;
        logic [35:0] exp_fields;
        bit          exp_err_q[$];
        logic [31:0] exp_rd_q[$];
        n = cmds.size(); ci = 0; ri = 0; t = 0;
        sl_busy = 0; sl_idx = 0; sl_waits = 0; sl_eph = 0;
        ack_cyc.delete(); rsp_cyc.delete();
        for (int i = 0; i < n; i++) begin
            ack_cyc.push_back(-1); rsp_cyc.push_back(-1);
            if (is_mis(cmds[i]) || cmds[i].err) begin
                exp_err_q.push_back(1'b1); exp_rd_q.push_back('0);
            end else if (cmds[i].wr) begin
                exp_err_q.push_back(1'b0); exp_rd_q.push_back('0);
                rmem[cmds[i].addr[5:2]] = cmds[i].wdata;
            end else begin
                exp_err_q.push_back(1'b0); exp_rd_q.push_back(rmem[cmds[i].addr[5:2]]);
            end
        end
        gap_left = (n > 0) ? cmds[0].gap : 0;
        while (ri < n && t < budget) begin
            req_now = (ci < n) && (gap_left == 0);
            cmd_req = req_now;
            if (req_now) begin
                cmd_addr = cmds[ci].addr; cmd_write = cmds[ci].wr;
                cmd_size = cmds[ci].size; cmd_wdata = cmds[ci].wdata;
            end else begin
                cmd_addr = $urandom; cmd_write = 1'($urandom_range(0, 1));
                cmd_size = 3'($urandom_range(0, 7)); cmd_wdata = $urandom;
            end
            pend2 = sl_busy && cmds[sl_idx].err && sl_waits == 0 && sl_eph == 1;
            hready = 1'b1;
            hresp[1] = 1'($urandom_range(0, 1));
            hresp[0] = 1'b0;
            hrdata = $urandom;
            if (sl_busy) begin
                if (sl_waits > 0) hready = 1'b0;
                else if (cmds[sl_idx].err) begin hresp[0] = 1'b1; hready = (sl_eph == 1); end
                else if (!cmds[sl_idx].wr) hrdata = smem[cmds[sl_idx].addr[5:2]];
            end else if ($urandom_range(0, 7) == 0) begin
                hresp[0] = 1'b1;  // stray ERROR with no data phase: must be ignored
            end
            mis_now   = req_now && is_mis(cmds[ci]);
            exp_trans = (req_now && !mis_now && !pend2) ? 2'b10 : 2'b00;
            exp_ack   = req_now && !pend2 && (mis_now ? !sl_busy : hready);
            exp_fields = (exp_trans == 2'b10) ? {cmds[ci].addr, cmds[ci].size, cmds[ci].wr} : '0;
            @(negedge clk);
            checks++;
            if (htrans !== exp_trans) begin
                failures++;
                $display("FAIL %s htrans t=%0d: got %0h expected %0h", name, t, htrans, exp_trans);
            end
            checks++;
            if (cmd_ack !== exp_ack) begin
                failures++;
                $display("FAIL %s cmd_ack t=%0d: got %0b expected %0b", name, t, cmd_ack, exp_ack);
            end
            checks++;
            if ({haddr, hsize, hwrite} !== exp_fields) begin
                failures++;
                $display("FAIL %s addr_phase t=%0d: got %h expected %h", name, t,
                         {haddr, hsize, hwrite}, exp_fields);
            end
            if (sl_busy && cmds[sl_idx].wr) begin
                checks++;
                if (hwdata !== cmds[sl_idx].wdata) begin
                    failures++;
                    $display("FAIL %s hwdata t=%0d: got %h expected %h", name, t, hwdata,
                             cmds[sl_idx].wdata);
                end
            end
            if (rsp_vld !== 1'b0) begin
                checks++;
                if (ri >= n) begin
                    failures++;
                    $display("FAIL %s extra_rsp t=%0d: got rsp_vld=%b expected none", name, t, rsp_vld);
                end else begin
                    if ({rsp_err, rsp_rdata} !== {exp_err_q[ri], exp_rd_q[ri]}) begin
                        failures++;
                        $display("FAIL %s rsp[%0d] t=%0d: got err=%b rdata=%h expected err=%b rdata=%h",
                                 name, ri, t, rsp_err, rsp_rdata, exp_err_q[ri], exp_rd_q[ri]);
                    end
                    rsp_cyc[ri] = t;
                    ri++;
                end
            end
            if (sl_busy) begin
                if (hready) begin
                    if (cmds[sl_idx].err) exp_errcnt = (exp_errcnt < 255) ? exp_errcnt + 1 : 255;
                    else if (cmds[sl_idx].wr) smem[cmds[sl_idx].addr[5:2]] = cmds[sl_idx].wdata;
                    sl_busy = 0;
                end else if (sl_waits > 0) begin
                    sl_waits--;
                end else begin
                    sl_eph = 1;
                end
            end
            if (exp_trans == 2'b10 && hready) begin
                sl_busy = 1; sl_idx = ci; sl_waits = cmds[ci].waits; sl_eph = 0;
            end
            if (exp_ack) begin
                ack_cyc[ci] = t;
                ci++;
                gap_left = (ci < n) ? cmds[ci].gap : 0;
            end else if (!req_now && gap_left > 0) begin
                gap_left--;
            end
            @(posedge clk); #1;
            t++;
        end
        cmd_req = 1'b0; hready = 1'b1; hresp = '0;
        checks++;
        if (ri < n) begin
            failures++;
            $display("FAIL %s timeout: got %0d responses expected %0d", name, ri, n);
        end
        checks++;
        if (err_cnt !== 8'(exp_errcnt)) begin
            failures++;
            $display("FAIL %s err_cnt: got %0d expected %0d", name, err_cnt, exp_errcnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_req = 1'b1; cmd_addr = 32'h40; cmd_size = 3'd2; cmd_write = 1'b0;
        hready = 1'b1; hresp = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({htrans, cmd_ack, rsp_vld, rsp_err, rsp_rdata, err_cnt, hwdata} !== '0) begin
            failures++;
            $display("FAIL reset_state: got htrans=%h ack=%b vld=%b err=%b rdata=%h cnt=%h hwdata=%h expected all 0",
                     htrans, cmd_ack, rsp_vld, rsp_err, rsp_rdata, err_cnt, hwdata);
        end
        cmd_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        smem[4] = 32'hDEAD_BEEF; rmem[4] = 32'hDEAD_BEEF;
        cmds.delete();
        cmds.push_back(mk(32'h10, 1'b0, 3'd2, '0, 0, 0, 0));
        run_cmds("single_read", 20);
        checks++;
        if (ack_cyc[0] !== 0 || rsp_cyc[0] !== 2) begin
            failures++;
            $display("FAIL single_read_latency: got ack=%0d rsp=%0d expected ack=0 rsp=2", ack_cyc[0], rsp_cyc[0]);
        end
    endtask

    task automatic test_back_to_back();
        cmds.delete();
        cmds.push_back(mk(32'h20, 1'b1, 3'd2, 32'h1234_5678, 0, 0, 0));
        cmds.push_back(mk(32'h20, 1'b0, 3'd2, '0, 0, 0, 0));
        run_cmds("back_to_back", 20);
        checks++;
        if (ack_cyc[0] !== 0 || ack_cyc[1] !== 1 || rsp_cyc[0] !== 2 || rsp_cyc[1] !== 3) begin
            failures++;
            $display("FAIL back_to_back_timing: got ack=%0d,%0d rsp=%0d,%0d expected 0,1 2,3",
                     ack_cyc[0], ack_cyc[1], rsp_cyc[0], rsp_cyc[1]);
        end
    endtask

    task automatic test_wait_states();
        cmds.delete();
        cmds.push_back(mk(32'h14, 1'b0, 3'd2, '0, 3, 0, 0));
        cmds.push_back(mk(32'h18, 1'b0, 3'd2, '0, 0, 0, 0));
        run_cmds("wait_states", 30);
        checks++;
        if (ack_cyc[1] !== 4 || rsp_cyc[0] !== 5 || rsp_cyc[1] !== 6) begin
            failures++;
            $display("FAIL wait_states_timing: got ack1=%0d rsp=%0d,%0d expected 4 5,6",
                     ack_cyc[1], rsp_cyc[0], rsp_cyc[1]);
        end
    endtask

    task automatic test_error();
        cmds.delete();
        cmds.push_back(mk(32'h24, 1'b0, 3'd2, '0, 0, 1, 0));
        cmds.push_back(mk(32'h28, 1'b0, 3'd2, '0, 0, 0, 0));
        run_cmds("error", 30);
        checks++;
        if (rsp_cyc[0] !== 3 || ack_cyc[1] !== 3 || err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL error_timing: got rsp0=%0d ack1=%0d err_cnt=%0d expected 3 3 1",
                     rsp_cyc[0], ack_cyc[1], err_cnt);
        end
    endtask

    task automatic test_misaligned();
        cmds.delete();
        cmds.push_back(mk(32'h2, 1'b0, 3'd2, '0, 0, 0, 0));
        run_cmds("misaligned_alone", 20);
        checks++;
        if (ack_cyc[0] !== 0 || rsp_cyc[0] !== 1) begin
            failures++;
            $display("FAIL misaligned_alone_timing: got ack=%0d rsp=%0d expected 0 1", ack_cyc[0], rsp_cyc[0]);
        end
        cmds.delete();
        cmds.push_back(mk(32'h30, 1'b1, 3'd2, 32'hA5A5_0F0F, 0, 0, 0));
        cmds.push_back(mk(32'h31, 1'b0, 3'd1, '0, 0, 0, 0));
        run_cmds("misaligned_after_write", 20);
        checks++;
        if (rsp_cyc[0] !== 2 || ack_cyc[1] !== 2 || rsp_cyc[1] !== 3) begin
            failures++;
            $display("FAIL misaligned_order: got rsp0=%0d ack1=%0d rsp1=%0d expected 2 2 3",
                     rsp_cyc[0], ack_cyc[1], rsp_cyc[1]);
        end
    endtask

    task automatic test_random();
        logic [2:0]  sz;
        logic [31:0] a;
        cmds.delete();
        for (int i = 0; i < 80; i++) begin
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 3'd1) a[0] = 1'b0;
                if (sz == 3'd2) a[1:0] = 2'b00;
            end
            cmds.push_back(mk(a, 1'($urandom_range(0, 1)), sz, $urandom,
                              ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                              $urandom_range(0, 7) == 0,
                              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0));
        end
        run_cmds("random", 2000);
    endtask

    task automatic test_saturation();
        cmds.delete();
        for (int i = 0; i < 258; i++) begin
            cmds.push_back(mk({$urandom_range(0, 15), 2'b00}, 1'($urandom_range(0, 1)), 3'd2,
                              $urandom, 0, 1, 0));
        end
        run_cmds("saturation", 1500);
        checks++;
        if (err_cnt !== 8'hFF) begin
            failures++;
            $display("FAIL err_cnt_saturate: got %0d expected 255", err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        cmd_req = 1'b1; cmd_addr = 32'h44; cmd_size = 3'd2; cmd_write = 1'b0;
        hready = 1'b1; hresp = '0;
        @(negedge clk);
        checks++;
        if (cmd_ack !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_accept: got cmd_ack=%b expected 1", cmd_ack);
        end
        @(posedge clk); #1;
        cmd_addr = 32'h48; hready = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({htrans, cmd_ack, rsp_vld, err_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_mid_state: got htrans=%h ack=%b vld=%b cnt=%0d expected 0 0 0 0",
                     htrans, cmd_ack, rsp_vld, err_cnt);
        end
        @(posedge clk); #1;
        cmd_req = 1'b0; rst = 1'b0; hready = 1'b1;
        exp_errcnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_vld !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_no_rsp: got rsp_vld=%b expected 0 (cycle %0d)", rsp_vld, i);
            end
            @(posedge clk); #1;
        end
        cmds.delete();
        cmds.push_back(mk(32'h10, 1'b0, 3'd2, '0, 0, 0, 0));
        run_cmds("read_after_reset", 20);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            smem[i] = $urandom;
            rmem[i] = smem[i];
        end
        test_reset();
        test_single_read();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_misaligned();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
